sram_port_arbiter: RTL and testbench

- Shares one single-port synchronous data/instruction SRAM between two requesters: the fetch stage (inst) and the execute stage (data, load/store).
- Arbitrates one access per cycle and routes the 1-cycle-latency read data back to the owner.
- Data wins by default; a streak counter prevents fetch starvation.
- Sits between the pipeline stages and the shared SRAM macro.

---
 rtl/sram_port_arbiter_if.sv | 38 +++
 rtl/sram_port_arbiter.sv | 69 ++++++
 tb/tb_sram_port_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_if.sv
// Bundle of the two pipeline request ports and the shared SRAM port seen by sram_port_arbiter.
// Handshake: a requester holds *_req and its fields stable until *_addr_ok is high in the same cycle
// (that cycle is the transfer); *_data_ok follows exactly one cycle later and cannot be back-pressured.
interface sram_port_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    // Requesters and the SRAM macro together drive the arbiter's inputs.
    modport master (
        output inst_req, inst_addr, data_req, data_wr, data_wstrb, data_addr, data_wdata, sram_rdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata,
        input  sram_en, sram_we, sram_addr, sram_wdata
    );

    modport slave (
        input  inst_req, inst_addr, data_req, data_wr, data_wstrb, data_addr, data_wdata, sram_rdata,
        output inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata,
        output sram_en, sram_we, sram_addr, sram_wdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one single-port synchronous SRAM between fetch (inst) and execute (data) requesters.
// Data wins by default; a streak counter forces one inst grant after MAX_DATA_STREAK data grants.
module sram_port_arbiter #(
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    sram_port_arbiter_if.slave   bus,
    output logic [3:0]           dbg_streak
);
    localparam logic [3:0] MAX_STREAK = 4'(MAX_DATA_STREAK);

    logic [3:0] streak;
    logic       resp_valid;
    logic       resp_owner;   // 0 = inst, 1 = data
    logic       reset_q;      // high in the first cycle after reset; blocks grants
    logic       accept_en;
    logic       grant_inst;
    logic       grant_data;

    always_comb begin
        accept_en  = !reset && !reset_q;
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (accept_en) begin
            if (bus.inst_req && bus.data_req) begin
                if (streak == MAX_STREAK) grant_inst = 1'b1;
                else                      grant_data = 1'b1;
            end else begin
                grant_inst = bus.inst_req;
                grant_data = bus.data_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            streak     <= 4'd0;
            resp_valid <= 1'b0;
            resp_owner <= 1'b0;
            reset_q    <= 1'b1;
        end else begin
            reset_q    <= 1'b0;
            resp_valid <= grant_inst | grant_data;
            resp_owner <= grant_data;
            // Only counts data grants that actually made fetch wait.
            if (grant_data && bus.inst_req)
                streak <= (streak == MAX_STREAK) ? MAX_STREAK : streak + 4'd1;
            else if (grant_inst || !bus.inst_req)
                streak <= 4'd0;
        end
    end

    assign bus.inst_addr_ok = grant_inst;
    assign bus.data_addr_ok = grant_data;

    assign bus.sram_en    = grant_inst | grant_data;
    assign bus.sram_addr  = grant_data ? bus.data_addr : bus.inst_addr;
    assign bus.sram_we    = (grant_data && bus.data_wr) ? bus.data_wstrb : 4'h0;
    assign bus.sram_wdata = bus.data_wdata;

    // A response whose grant precedes a reset is dropped while reset is held.
    assign bus.inst_data_ok = resp_valid && !resp_owner && !reset;
    assign bus.data_data_ok = resp_valid &&  resp_owner && !reset;
    assign bus.inst_rdata   = bus.sram_rdata;
    assign bus.data_rdata   = bus.sram_rdata;

    assign dbg_streak = streak;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: reset, single accesses, contention, alternation,
// mid-flight reset and idle behaviour, all against hand-computed values.
module tb_sram_port_arbiter;
  logic       clk;
  logic       reset;
  logic [3:0] dbg_streak;

  int n_vec;
  int n_bad;

  logic       exp_q[$];   // expected grant owner per contention cycle, 1 = data
  logic [3:0] exp_streak [10];
  logic       own;
  logic       prev_owner;

  sram_port_arbiter_if bus ();

  sram_port_arbiter #(.MAX_DATA_STREAK(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .dbg_streak (dbg_streak)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.inst_req   = 1'b0;
    bus.data_req   = 1'b0;
    bus.data_wr    = 1'b0;
    bus.data_wstrb = 4'h0;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;
    drive_idle();
    bus.inst_addr  = 32'h0;
    bus.data_addr  = 32'h0;
    bus.data_wdata = 32'h0;
    bus.sram_rdata = 32'h0;

    // reset held with a fetch pending: nothing may be granted
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h1c00_0000;
    next_cycle();
    @(negedge clk);
    check("rst_inst_addr_ok", 32'(bus.inst_addr_ok), 32'h0);
    check("rst_sram_en", 32'(bus.sram_en), 32'h0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_inst_addr_ok", 32'(bus.inst_addr_ok), 32'h0);
    check("post_rst_sram_en", 32'(bus.sram_en), 32'h0);
    check("post_rst_data_ok", {30'h0, bus.inst_data_ok, bus.data_data_ok}, 32'h0);
    check("post_rst_streak", 32'(dbg_streak), 32'h0);

    // first fetch
    next_cycle();
    @(negedge clk);
    check("fetch_addr_ok", 32'(bus.inst_addr_ok), 32'h1);
    check("fetch_sram_en", 32'(bus.sram_en), 32'h1);
    check("fetch_sram_we", 32'(bus.sram_we), 32'h0);
    check("fetch_sram_addr", bus.sram_addr, 32'h1c00_0000);
    check("fetch_no_data_ok", 32'(bus.data_addr_ok), 32'h0);
    next_cycle();
    bus.inst_req   = 1'b0;
    bus.sram_rdata = 32'h0280_0000;
    @(negedge clk);
    check("fetch_inst_data_ok", 32'(bus.inst_data_ok), 32'h1);
    check("fetch_inst_rdata", bus.inst_rdata, 32'h0280_0000);
    check("fetch_data_data_ok", 32'(bus.data_data_ok), 32'h0);

    // partial-word store
    bus.data_req   = 1'b1;
    bus.data_wr    = 1'b1;
    bus.data_wstrb = 4'b0011;
    bus.data_addr  = 32'h100;
    bus.data_wdata = 32'hdead_beef;
    @(negedge clk);
    check("store_addr_ok", 32'(bus.data_addr_ok), 32'h1);
    check("store_sram_we", 32'(bus.sram_we), 32'h3);
    check("store_sram_addr", bus.sram_addr, 32'h100);
    check("store_sram_wdata", bus.sram_wdata, 32'hdead_beef);
    next_cycle();
    // load with strobes left high must not write
    bus.data_wr    = 1'b0;
    bus.data_wstrb = 4'hf;
    bus.data_addr  = 32'h104;
    @(negedge clk);
    check("store_data_ok", 32'(bus.data_data_ok), 32'h1);
    check("store_no_inst_ok", 32'(bus.inst_data_ok), 32'h0);
    check("load_sram_we", 32'(bus.sram_we), 32'h0);
    check("load_sram_addr", bus.sram_addr, 32'h104);
    next_cycle();
    drive_idle();
    bus.sram_rdata = 32'h5555_aaaa;
    @(negedge clk);
    check("load_data_ok", 32'(bus.data_data_ok), 32'h1);
    check("load_rdata", bus.data_rdata, 32'h5555_aaaa);
    next_cycle();

    // contention: D,D,D,D,I,D,D,D,D,I
    exp_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_streak = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h1c00_0010;
    bus.data_req  = 1'b1;
    bus.data_wr   = 1'b0;
    bus.data_addr = 32'h200;
    prev_owner    = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.sram_rdata = 32'ha000_0000 + 32'(i);
      @(negedge clk);
      own = exp_q.pop_front();
      check($sformatf("cont%0d_streak", i), 32'(dbg_streak), 32'(exp_streak[i]));
      check($sformatf("cont%0d_inst_addr_ok", i), 32'(bus.inst_addr_ok), 32'(!own));
      check($sformatf("cont%0d_data_addr_ok", i), 32'(bus.data_addr_ok), 32'(own));
      check($sformatf("cont%0d_sram_addr", i), bus.sram_addr, own ? 32'h200 : 32'h1c00_0010);
      if (i > 0) begin
        check($sformatf("cont%0d_inst_data_ok", i), 32'(bus.inst_data_ok), 32'(!prev_owner));
        check($sformatf("cont%0d_data_data_ok", i), 32'(bus.data_data_ok), 32'(prev_owner));
        check($sformatf("cont%0d_rdata", i), prev_owner ? bus.data_rdata : bus.inst_rdata,
              32'ha000_0000 + 32'(i));
      end
      prev_owner = own;
      next_cycle();
    end
    drive_idle();
    bus.sram_rdata = 32'ha000_000a;
    @(negedge clk);
    check("cont_last_inst_data_ok", 32'(bus.inst_data_ok), 32'h1);
    check("cont_last_data_data_ok", 32'(bus.data_data_ok), 32'h0);
    check("cont_last_rdata", bus.inst_rdata, 32'ha000_000a);
    next_cycle();

    // alternating I,D,I,D with no bubble
    for (int k = 0; k < 4; k++) begin
      own            = k[0];
      bus.inst_req   = !own;
      bus.data_req   = own;
      bus.sram_rdata = 32'hb000_0000 + 32'(k);
      @(negedge clk);
      check($sformatf("alt%0d_inst_addr_ok", k), 32'(bus.inst_addr_ok), 32'(!own));
      check($sformatf("alt%0d_data_addr_ok", k), 32'(bus.data_addr_ok), 32'(own));
      if (k > 0) begin
        check($sformatf("alt%0d_inst_data_ok", k), 32'(bus.inst_data_ok), 32'(!prev_owner));
        check($sformatf("alt%0d_data_data_ok", k), 32'(bus.data_data_ok), 32'(prev_owner));
      end
      prev_owner = own;
      next_cycle();
    end
    drive_idle();
    bus.sram_rdata = 32'hb000_0004;
    @(negedge clk);
    check("alt_last_data_data_ok", 32'(bus.data_data_ok), 32'h1);
    check("alt_last_inst_data_ok", 32'(bus.inst_data_ok), 32'h0);
    check("alt_last_rdata", bus.data_rdata, 32'hb000_0004);
    next_cycle();

    // reset the cycle after a load grant
    bus.inst_req = 1'b1;
    bus.data_req = 1'b1;
    @(negedge clk);
    check("pre_rst_grant0", 32'(bus.data_addr_ok), 32'h1);
    next_cycle();
    @(negedge clk);
    check("pre_rst_grant1", 32'(bus.data_addr_ok), 32'h1);
    next_cycle();
    reset = 1'b1;
    drive_idle();
    @(negedge clk);
    check("mid_rst_streak", 32'(dbg_streak), 32'h2);
    check("mid_rst_data_data_ok", 32'(bus.data_data_ok), 32'h0);
    check("mid_rst_inst_data_ok", 32'(bus.inst_data_ok), 32'h0);
    next_cycle();
    reset        = 1'b0;
    bus.inst_req = 1'b1;
    bus.data_req = 1'b1;
    @(negedge clk);
    check("after_rst_data_data_ok", 32'(bus.data_data_ok), 32'h0);
    check("after_rst_streak", 32'(dbg_streak), 32'h0);
    check("after_rst_blocked", {30'h0, bus.inst_addr_ok, bus.data_addr_ok}, 32'h0);
    next_cycle();
    @(negedge clk);
    check("after_rst_data_first", {30'h0, bus.inst_addr_ok, bus.data_addr_ok}, 32'h1);
    next_cycle();
    drive_idle();
    next_cycle();

    // idle for 5 cycles
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check($sformatf("idle%0d", j),
            {23'h0, bus.sram_en, bus.sram_we, bus.inst_addr_ok, bus.data_addr_ok,
             bus.inst_data_ok, bus.data_data_ok}, 32'h0);
      next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
